branch_predictor: RTL

Dynamic branch direction predictor for the 3-stage RISC-V core. It holds a direct-mapped table of 2-bit saturating counters, indexed by PC. In fetch it supplies the taken/not-taken prediction that the execute-stage PC-select logic later checks. In execute it consumes that logic's branch-check and branch-outcome signals to train the table and keep performance counters.

---
 rtl/branch_predictor.sv | 83 ++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters for branch direction prediction.
// Predicts combinationally in fetch, trains and counts performance events from execute checks.
module branch_predictor #(
    parameter int N_ENTRIES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_en,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_is_br,
    output logic        pred_taken,
    input  logic        check_valid,
    input  logic        check_taken,
    input  logic        check_pred,
    input  logic [31:0] check_pc,
    input  logic        perf_clr,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);
    localparam int INDEX_W = $clog2(N_ENTRIES);

    logic [N_ENTRIES-1:0][1:0] table_q, table_d;
    logic                      mispredict_q, mispredict_d;
    logic [31:0]               br_count_q, br_count_d;
    logic [31:0]               mispred_count_q, mispred_count_d;

    logic [INDEX_W-1:0] rd_idx, upd_idx;
    logic [1:0]         upd_cur;
    logic               mispred;

    assign rd_idx  = fetch_pc[INDEX_W+1:2];
    assign upd_idx = check_pc[INDEX_W+1:2];
    assign upd_cur = table_q[upd_idx];
    assign mispred = check_valid & (check_pred != check_taken);

    // Read the registered table: a same-cycle update to this entry is not bypassed.
    assign pred_taken = pred_en & fetch_is_br & table_q[rd_idx][1];

    always_comb begin
        table_d = table_q;
        if (check_valid) begin
            if (check_taken && upd_cur != 2'b11)
                table_d[upd_idx] = upd_cur + 2'd1;
            else if (!check_taken && upd_cur != 2'b00)
                table_d[upd_idx] = upd_cur - 2'd1;
        end
    end

    always_comb begin
        mispredict_d    = mispred;
        br_count_d      = br_count_q + {31'd0, check_valid};
        mispred_count_d = mispred_count_q + {31'd0, mispred};
        if (perf_clr) begin
            br_count_d      = '0;
            mispred_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q         <= {N_ENTRIES{2'b01}};
            mispredict_q    <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            table_q         <= table_d;
            mispredict_q    <= mispredict_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign mispredict    = mispredict_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

    // Only the index bits of the PCs select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[31:INDEX_W+2], fetch_pc[1:0],
                              check_pc[31:INDEX_W+2], check_pc[1:0]};

endmodule
